// File: rtl/dtcm_port_arbiter.sv
// Two-master DTCM arbiter: IDLE->BUSY->DONE; grant to ready is 2 cycles plus wait states; BUSY is bounded by TIMEOUT_CYCLES.
// Backpressure: a master holds req until its one-cycle ready; tie rule set by DTCM_ARB_ROUND_ROBIN_EN (else fixed m0 priority).
module dtcm_port_arbiter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic                  m0_rw_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_ready_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                  m1_rw_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_ready_o,
    output logic                  dtcm_en_o,
    output logic [ADDR_WIDTH-1:0] dtcm_addr_o,
    output logic [DATA_WIDTH-1:0] dtcm_wdata_o,
    output logic                  dtcm_rw_o,
    input  logic [DATA_WIDTH-1:0] dtcm_rdata_i,
    input  logic                  dtcm_ready_i,
    output logic                  owner_o,
    output logic                  err_timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m0_ready_q, m0_ready_d;
    logic                  m1_ready_q, m1_ready_d;
    logic                  err_q, err_d;

    logic                  grant_sel;
    logic                  cpl_vld;
    logic [DATA_WIDTH-1:0] cpl_dat;

    // grant_sel is only meaningful when at least one request is present
    always_comb begin
`ifdef DTCM_ARB_ROUND_ROBIN_EN
        if (m0_req_i && m1_req_i) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = ~m0_req_i;
        end
`else
        grant_sel = ~m0_req_i;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        err_d      = 1'b0;
        cpl_vld    = 1'b0;
        cpl_dat    = '0;

        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d = grant_sel;
                    last_d  = grant_sel;
                    addr_d  = grant_sel ? m1_addr_i  : m0_addr_i;
                    wdata_d = grant_sel ? m1_wdata_i : m0_wdata_i;
                    rw_d    = grant_sel ? m1_rw_i    : m0_rw_i;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real completion on the terminal cycle beats the timeout
                if (dtcm_ready_i) begin
                    cpl_vld = 1'b1;
                    cpl_dat = rw_q ? '0 : dtcm_rdata_i;
                end else if (cnt_q == CNT_TC) begin
                    cpl_vld = 1'b1;
                    cpl_dat = rw_q ? '0 : ERR_DATA;
                    err_d   = 1'b1;
                end
                if (cpl_vld) begin
                    if (owner_q) begin
                        m1_rdata_d = cpl_dat;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = cpl_dat;
                        m0_ready_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            err_q      <= err_d;
        end
    end

    assign dtcm_en_o     = (state_q == S_BUSY);
    assign dtcm_addr_o   = addr_q;
    assign dtcm_wdata_o  = wdata_q;
    assign dtcm_rw_o     = rw_q;
    assign owner_o       = owner_q;
    assign m0_rdata_o    = m0_rdata_q;
    assign m1_rdata_o    = m1_rdata_q;
    assign m0_ready_o    = m0_ready_q;
    assign m1_ready_o    = m1_ready_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Directed bench for dtcm_port_arbiter: single accesses, wait states, tie arbitration, timeout and mid-access reset.
module tb_dtcm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0;
    logic [31:0] m0_wdata_i = '0;
    logic        m0_rw_i = 1'b0;
    logic [31:0] m0_rdata_o;
    logic        m0_ready_o;
    logic        m1_req_i = 1'b0;
    logic [31:0] m1_addr_i = '0;
    logic [31:0] m1_wdata_i = '0;
    logic        m1_rw_i = 1'b0;
    logic [31:0] m1_rdata_o;
    logic        m1_ready_o;
    logic        dtcm_en_o;
    logic [31:0] dtcm_addr_o;
    logic [31:0] dtcm_wdata_o;
    logic        dtcm_rw_o;
    logic [31:0] dtcm_rdata_i = '0;
    logic        dtcm_ready_i = 1'b0;
    logic        owner_o;
    logic        err_timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    dtcm_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_rw_i      (m0_rw_i),
        .m0_rdata_o   (m0_rdata_o),
        .m0_ready_o   (m0_ready_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_rw_i      (m1_rw_i),
        .m1_rdata_o   (m1_rdata_o),
        .m1_ready_o   (m1_ready_o),
        .dtcm_en_o    (dtcm_en_o),
        .dtcm_addr_o  (dtcm_addr_o),
        .dtcm_wdata_o (dtcm_wdata_o),
        .dtcm_rw_o    (dtcm_rw_o),
        .dtcm_rdata_i (dtcm_rdata_i),
        .dtcm_ready_i (dtcm_ready_i),
        .owner_o      (owner_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_own;

        // Reset state
        #2;
        check("rst_en", {31'd0, dtcm_en_o}, 32'd0);
        check("rst_owner", {31'd0, owner_o}, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready_o}, 32'd0);
        check("rst_err", {31'd0, err_timeout_o}, 32'd0);
        check("rst_addr", dtcm_addr_o, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // dtcm_ready outside BUSY must be ignored
        dtcm_ready_i = 1'b1;
        dtcm_rdata_i = 32'hFFFF_0000;
        tick();
        check("idle_rdy_m0", {31'd0, m0_ready_o}, 32'd0);
        check("idle_rdy_m1", {31'd0, m1_ready_o}, 32'd0);
        check("idle_rdy_en", {31'd0, dtcm_en_o}, 32'd0);
        dtcm_ready_i = 1'b0;

        // Master 0 read, zero wait states
        m0_req_i = 1'b1; m0_addr_i = 32'h10; m0_rw_i = 1'b0;
        tick();
        check("t1_en", {31'd0, dtcm_en_o}, 32'd1);
        check("t1_addr", dtcm_addr_o, 32'h10);
        check("t1_rw", {31'd0, dtcm_rw_o}, 32'd0);
        check("t1_owner", {31'd0, owner_o}, 32'd0);
        check("t1_early_rdy", {31'd0, m0_ready_o}, 32'd0);
        dtcm_ready_i = 1'b1; dtcm_rdata_i = 32'hA5A5_0001;
        tick();
        check("t1_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        check("t1_m0_rdata", m0_rdata_o, 32'hA5A5_0001);
        check("t1_m1_ready", {31'd0, m1_ready_o}, 32'd0);
        check("t1_done_en", {31'd0, dtcm_en_o}, 32'd0);
        m0_req_i = 1'b0; dtcm_ready_i = 1'b0;
        tick();
        check("t1_pulse_end", {31'd0, m0_ready_o}, 32'd0);
        check("t1_addr_hold", dtcm_addr_o, 32'h10);

        // Master 1 write, three wait states
        m1_req_i = 1'b1; m1_addr_i = 32'h20; m1_wdata_i = 32'h1234_5678; m1_rw_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_en", {31'd0, dtcm_en_o}, 32'd1);
            check("t2_rw", {31'd0, dtcm_rw_o}, 32'd1);
            check("t2_wdata", dtcm_wdata_o, 32'h1234_5678);
            check("t2_rdy_wait", {31'd0, m1_ready_o}, 32'd0);
            m1_wdata_i = 32'hBAD0_0000 + k;
            if (k == 4) begin
                dtcm_ready_i = 1'b1; dtcm_rdata_i = 32'h7777_7777;
            end
        end
        tick();
        check("t2_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        check("t2_m1_rdata", m1_rdata_o, 32'd0);
        check("t2_m0_ready", {31'd0, m0_ready_o}, 32'd0);
        check("t2_owner", {31'd0, owner_o}, 32'd1);
        m1_req_i = 1'b0; dtcm_ready_i = 1'b0;
        tick();

        // Both masters request continuously for four accesses
        m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_rw_i = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 32'h200; m1_rw_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
`ifdef DTCM_ARB_ROUND_ROBIN_EN
            exp_own = a % 2;
`else
            exp_own = 0;
`endif
            tick();
            check("t3_owner", {31'd0, owner_o}, exp_own);
            check("t3_addr", dtcm_addr_o, (exp_own == 1) ? 32'h200 : 32'h100);
            dtcm_ready_i = 1'b1; dtcm_rdata_i = 32'hC0DE_0000 + a;
            tick();
            check("t3_m0_ready", {31'd0, m0_ready_o}, (exp_own == 0) ? 32'd1 : 32'd0);
            check("t3_m1_ready", {31'd0, m1_ready_o}, (exp_own == 1) ? 32'd1 : 32'd0);
            dtcm_ready_i = 1'b0;
            if (a == 3) begin
                m0_req_i = 1'b0; m1_req_i = 1'b0;
            end
            tick();
        end
        check("t3_idle_en", {31'd0, dtcm_en_o}, 32'd0);

        // Timeout on a master 0 read
        m0_req_i = 1'b1; m0_addr_i = 32'h30; m0_rw_i = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) begin
            check("t4_en", {31'd0, dtcm_en_o}, 32'd1);
            check("t4_rdy_wait", {31'd0, m0_ready_o}, 32'd0);
            check("t4_err_wait", {31'd0, err_timeout_o}, 32'd0);
            tick();
        end
        check("t4_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        check("t4_err", {31'd0, err_timeout_o}, 32'd1);
        check("t4_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("t4_en_off", {31'd0, dtcm_en_o}, 32'd0);
        m0_req_i = 1'b0;
        tick();
        check("t4_err_end", {31'd0, err_timeout_o}, 32'd0);

        // dtcm_ready on the 16th BUSY cycle wins over the timeout
        m0_req_i = 1'b1; m0_addr_i = 32'h34;
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                dtcm_ready_i = 1'b1; dtcm_rdata_i = 32'h5555_AAAA;
            end
            tick();
        end
        check("t5_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        check("t5_err", {31'd0, err_timeout_o}, 32'd0);
        check("t5_rdata", m0_rdata_o, 32'h5555_AAAA);
        m0_req_i = 1'b0; dtcm_ready_i = 1'b0;
        tick();

        // Reset in the second BUSY cycle, with master 1 waiting
        m0_req_i = 1'b1; m0_addr_i = 32'h44; m0_wdata_i = 32'h0F0F_0F0F; m0_rw_i = 1'b1;
        tick();
        m1_req_i = 1'b1; m1_addr_i = 32'h48; m1_rw_i = 1'b0;
        tick();
        check("t6_busy2", {31'd0, dtcm_en_o}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_en", {31'd0, dtcm_en_o}, 32'd0);
        check("t6_rst_addr", dtcm_addr_o, 32'd0);
        check("t6_rst_wdata", dtcm_wdata_o, 32'd0);
        check("t6_rst_rw", {31'd0, dtcm_rw_o}, 32'd0);
        check("t6_rst_m0_rdata", m0_rdata_o, 32'd0);
        check("t6_rst_m0_ready", {31'd0, m0_ready_o}, 32'd0);
        m0_req_i = 1'b0;
        tick();
        check("t6_held_ready", {31'd0, m0_ready_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("t6_m1_grant", {31'd0, dtcm_en_o}, 32'd1);
        check("t6_m1_owner", {31'd0, owner_o}, 32'd1);
        check("t6_m1_addr", dtcm_addr_o, 32'h48);
        check("t6_no_m0_ready", {31'd0, m0_ready_o}, 32'd0);
        dtcm_ready_i = 1'b1; dtcm_rdata_i = 32'h1357_9BDF;
        tick();
        check("t6_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        check("t6_m1_rdata", m1_rdata_o, 32'h1357_9BDF);
        m1_req_i = 1'b0; dtcm_ready_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dtcm_port_arbiter.md
# dtcm_port_arbiter

Two-master arbiter for the single-port DTCM. It sits between the memory-map decoder's DTCM interface (master 0, the CPU load/store path) and a second requester (master 1, the DMA/debug port) on one side, and the DTCM macro on the other. It serialises accesses with a request/ready handshake, grants round-robin or fixed-priority, and bounds every access with a timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of masters and DTCM
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY before forced completion (≥1)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timed-out read

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ready
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wdata  in  DATA_WIDTH  master 0 write data
- m0_rw  in  1  1 = write, 0 = read
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_ready
- m0_ready  out  1  one-cycle completion pulse
- m1_req, m1_addr, m1_wdata, m1_rw, m1_rdata, m1_ready: same as m0_* for master 1
- dtcm_en  out  1  access valid, held high for the whole BUSY state
- dtcm_addr  out  ADDR_WIDTH  latched winner address
- dtcm_wdata  out  DATA_WIDTH  latched winner write data
- dtcm_rw  out  1  latched winner direction
- dtcm_rdata  in  DATA_WIDTH  DTCM read data, valid with dtcm_ready
- dtcm_ready  in  1  DTCM completion
- owner  out  1  master currently or last granted
- err_timeout  out  1  one-cycle pulse on forced completion

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If one request is present, grant it.
  - If both m0_req and m1_req are present, apply the arbitration rule (see Configuration).
  - On grant: latch addr, wdata and rw into the dtcm_* registers, set owner, clear the timeout counter, and go to BUSY.
- BUSY:
  - dtcm_en = 1; the counter increments each cycle.
  - If dtcm_ready = 1: latch rdata (dtcm_rdata for reads, 0 for writes) into the owner's mX_rdata, pulse mX_ready, and go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: complete the access with rdata = ERR_DATA (0 for writes), pulse mX_ready and err_timeout, and go to DONE.
- DONE:
  - dtcm_en = 0 and mX_ready = 1 for the owner only.
  - Unconditionally go to IDLE.
  - Requests are not sampled in DONE.
- The non-owner's ready is never asserted. The non-owner's rdata holds its previous value.
- Master obligations:
  - Hold req, addr, wdata and rw stable from assertion until ready.
  - Drop req on the clock edge after ready, or keep it high to issue a new access.
- Changes to a master's inputs while it is not granted are ignored. Once latched, the DTCM request is immune to master changes.
- dtcm_rw, dtcm_addr and dtcm_wdata hold their last values outside BUSY.

## Timing
- Reset values: state IDLE; dtcm_en, dtcm_rw, m0_ready, m1_ready, err_timeout = 0; all address and data outputs 0; owner = 0; last-grant register = 1, so master 0 wins the first tie.
- Reset mid-access: abort immediately, with no ready pulse.
- Latency: a req sampled in IDLE at cycle 0 puts dtcm_en high at cycle 1. A zero-wait DTCM (dtcm_ready in cycle 1) gives mX_ready at cycle 2.
  - Minimum back-to-back issue interval is 3 cycles (IDLE, BUSY, DONE).
- Wait states: each wait-state cycle of dtcm_ready adds one cycle of latency.
- Timeout: with no dtcm_ready, ready arrives TIMEOUT_CYCLES+1 cycles after the grant edge.
- dtcm_ready in the same cycle as the timeout terminal count: ready wins, and err_timeout stays 0.
- dtcm_ready outside BUSY is ignored.

## Configuration
- Macro DTCM_ARB_ROUND_ROBIN_EN selects the arbitration rule; it only matters when both masters request in the same IDLE cycle.
- Defined: on a tie, grant the master that is not the last-grant register. The last-grant register updates on every grant.
- Undefined: fixed priority, master 0 always wins a tie. The last-grant register is still reset and updated but does not affect arbitration.

## Test plan
- Single master 0 read, addr 0x10, DTCM returns 0xA5A5_0001 with 0 wait states → m0_ready at cycle 2 with m0_rdata = 0xA5A5_0001; m1_ready stays 0.
- Master 1 write, addr 0x20, wdata 0x1234_5678, 3 wait states → dtcm_en high for 4 cycles with dtcm_rw = 1 and dtcm_wdata = 0x1234_5678; m1_ready at cycle 5 with m1_rdata = 0.
- Both masters hold req continuously for 4 accesses:
  - With DTCM_ARB_ROUND_ROBIN_EN defined → grant order 0,1,0,1.
  - Without the macro → order 0,0,0,0, and m1 never granted while m0_req stays high.
- DTCM never asserts ready on a m0 read, TIMEOUT_CYCLES = 16 → m0_ready and err_timeout pulse together 17 cycles after the grant, m0_rdata = 0xDEAD_BEEF; next access proceeds normally.
- dtcm_ready coincident with the 16th BUSY cycle → normal completion with DTCM data; err_timeout stays 0.
- rst asserted in the second BUSY cycle → all outputs 0 asynchronously, no ready pulse; after release, a pending m1_req is granted 1 cycle later.
